// File: rtl/alu_sequencer.sv
// alu_sequencer: issue-side controller for a 32-bit combinational ALU.
// Commands name source/destination registers in a small internal register file. Each command
// is issued to the ALU for one cycle, the result is written back and returned on a response
// handshake.
module alu_sequencer #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_COUNT = 8,
  parameter int unsigned ADDR_W    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  // Command handshake
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic              cmd_imm_en,
  input  logic [DATA_W-1:0] cmd_imm,
  // Host preload port
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  // ALU side
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_cnt,
  input  logic [DATA_W-1:0] alu_d,
  // Response handshake
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_rd,
  output logic              rsp_err,
  output logic              busy
);

  localparam logic [3:0] MaxOp = 4'd12;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] rf_q [REG_COUNT];
  logic [DATA_W-1:0] op_a_q;
  logic [DATA_W-1:0] op_b_q;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] res_q;
  logic              err_q;
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic              busy_q;

  // Sequencer FSM, register file and all registered outputs.
  // The operand registers drive the ALU directly, so the ALU inputs are valid throughout EXEC
  // and hold their last values until the next command is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        rf_q[i] <= '0;
      end
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_q        <= '0;
      rd_q        <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          // Operands are read from the pre-write contents when a preload hits the same cycle.
          if (wr_en) begin
            rf_q[wr_addr] <= wr_data;
          end
          if (cmd_valid) begin
            op_a_q      <= rf_q[cmd_rs1];
            op_b_q      <= cmd_imm_en ? cmd_imm : rf_q[cmd_rs2];
            op_q        <= cmd_op;
            rd_q        <= cmd_rd;
            state_q     <= StExec;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        StExec: begin
          if (op_q <= MaxOp) begin
            res_q       <= alu_d;
            rf_q[rd_q]  <= alu_d;
            err_q       <= 1'b0;
          end else begin
            res_q       <= '0;
            err_q       <= 1'b1;
          end
          state_q     <= StResp;
          rsp_valid_q <= 1'b1;
        end
        StResp: begin
          if (rsp_ready) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Output wiring from registered state.
  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign alu_a     = op_a_q;
  assign alu_b     = op_b_q;
  assign alu_cnt   = op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = res_q;
  assign rsp_rd    = rd_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed and random commands against a behavioural register-file model.
// A stand-in combinational ALU is modelled in the bench to close the loop on alu_d.
module tb_alu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [2:0]  cmd_rs1;
  logic [2:0]  cmd_rs2;
  logic [2:0]  cmd_rd;
  logic        cmd_imm_en;
  logic [31:0] cmd_imm;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_cnt;
  logic [31:0] alu_d;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_rd;
  logic        rsp_err;
  logic        busy;

  int total;
  int bad;
  logic [31:0] rf [8];
  logic [31:0] got;

  alu_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_rs1    (cmd_rs1),
    .cmd_rs2    (cmd_rs2),
    .cmd_rd     (cmd_rd),
    .cmd_imm_en (cmd_imm_en),
    .cmd_imm    (cmd_imm),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cnt    (alu_cnt),
    .alu_d      (alu_d),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_rd     (rsp_rd),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU: unsupported codes return junk so the sequencer must zero the result itself.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
    logic [4:0] s;
    s = b[4:0];
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return (a == b) ? 32'hFFFF_FFFF : 32'h0;
      4'd3:    return (a < b) ? 32'hFFFF_FFFF : 32'h0;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return a ^ b;
      4'd7:    return ~a;
      4'd8:    return b;
      4'd9:    return (s == 5'd0) ? a : ((a << s) | (a >> (6'd32 - {1'b0, s})));
      4'd10:   return (s == 5'd0) ? a : ((a >> s) | (a << (6'd32 - {1'b0, s})));
      4'd11:   return a << s;
      4'd12:   return a >> s;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb alu_d = alu_fn(alu_a, alu_b, alu_cnt);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rf[a] = d;
  endtask

  // One full command: accept, EXEC, RESP (with optional stall), handshake.
  task automatic do_cmd(input logic [3:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                        input logic [2:0] rd, input logic ie, input logic [31:0] imm,
                        input int stall, input logic we, input logic [2:0] wa,
                        input logic [31:0] wd, output logic [31:0] obs);
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        err;
    a   = rf[rs1];
    b   = ie ? imm : rf[rs2];
    err = (op > 4'd12);
    exp = err ? 32'h0 : alu_fn(a, b, op);
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_rs1    = rs1;
    cmd_rs2    = rs2;
    cmd_rd     = rd;
    cmd_imm_en = ie;
    cmd_imm    = imm;
    wr_en      = we;
    wr_addr    = wa;
    wr_data    = wd;
    rsp_ready  = (stall == 0);
    check("idle_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wr_en     = 1'b0;
    if (we) rf[wa] = wd;
    check("exec_busy", {31'b0, busy}, 32'd1);
    check("exec_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("exec_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("exec_alu_a", alu_a, a);
    check("exec_alu_b", alu_b, b);
    check("exec_alu_cnt", {28'b0, alu_cnt}, {28'b0, op});
    @(posedge clk);
    #1;
    if (!err) rf[rd] = exp;
    obs = rsp_data;
    check("resp_valid", {31'b0, rsp_valid}, 32'd1);
    check("resp_data", rsp_data, exp);
    check("resp_rd", {29'b0, rsp_rd}, {29'b0, rd});
    check("resp_err", {31'b0, rsp_err}, {31'b0, err});
    for (int i = 0; i < stall; i++) begin
      // Preload attempts during the stall must be ignored.
      wr_en   = 1'b1;
      wr_addr = 3'd1;
      wr_data = $urandom;
      @(posedge clk);
      #1;
      check("stall_valid", {31'b0, rsp_valid}, 32'd1);
      check("stall_data", rsp_data, exp);
      check("stall_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      check("stall_err", {31'b0, rsp_err}, {31'b0, err});
    end
    wr_en     = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("done_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("done_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("done_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("done_busy", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = '0;
    cmd_rs1    = '0;
    cmd_rs2    = '0;
    cmd_rd     = '0;
    cmd_imm_en = 1'b0;
    cmd_imm    = '0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    rsp_ready  = 1'b0;
    for (int i = 0; i < 8; i++) rf[i] = 32'h0;

    // Reset state
    #12;
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic add and chained add
    preload(3'd1, 32'd5);
    preload(3'd2, 32'd3);
    do_cmd(4'd0, 3'd1, 3'd2, 3'd3, 1'b0, 32'd0, 0, 1'b0, 3'd0, 32'd0, got);
    check("add_5_3", got, 32'd8);
    do_cmd(4'd0, 3'd3, 3'd3, 3'd4, 1'b0, 32'd0, 0, 1'b0, 3'd0, 32'd0, got);
    check("add_8_8", got, 32'd16);
    do_cmd(4'd1, 3'd2, 3'd1, 3'd5, 1'b0, 32'd0, 0, 1'b0, 3'd0, 32'd0, got);
    check("sub_3_5", got, 32'hFFFF_FFFE);
    do_cmd(4'd3, 3'd2, 3'd1, 3'd7, 1'b0, 32'd0, 0, 1'b0, 3'd0, 32'd0, got);
    check("op3", got, 32'hFFFF_FFFF);
    do_cmd(4'd2, 3'd2, 3'd1, 3'd7, 1'b0, 32'd0, 0, 1'b0, 3'd0, 32'd0, got);
    check("op2", got, 32'h0);

    // Immediate rotates: full B is passed, ALU uses B[4:0]
    preload(3'd4, 32'h8000_0001);
    do_cmd(4'd9, 3'd4, 3'd0, 3'd0, 1'b1, 32'd4, 0, 1'b0, 3'd0, 32'd0, got);
    check("rotl_imm4", got, 32'h0000_0018);
    do_cmd(4'd10, 3'd4, 3'd0, 3'd0, 1'b1, 32'h24, 0, 1'b0, 3'd0, 32'd0, got);
    check("rotr_imm24", got, 32'h1800_0000);

    // Backpressure with ignored preload to r1, then confirm r1 unchanged
    do_cmd(4'd0, 3'd1, 3'd2, 3'd3, 1'b0, 32'd0, 5, 1'b0, 3'd0, 32'd0, got);
    do_cmd(4'd0, 3'd1, 3'd0, 3'd5, 1'b1, 32'd0, 0, 1'b0, 3'd0, 32'd0, got);
    check("r1_after_stall", got, 32'd5);

    // Unsupported opcode: zero result, error flag, no writeback
    preload(3'd6, 32'h55);
    do_cmd(4'd13, 3'd1, 3'd2, 3'd6, 1'b0, 32'd0, 0, 1'b0, 3'd0, 32'd0, got);
    check("bad_op_data", got, 32'h0);
    do_cmd(4'd0, 3'd6, 3'd0, 3'd7, 1'b1, 32'd0, 0, 1'b0, 3'd0, 32'd0, got);
    check("r6_kept", got, 32'h55);

    // Same-cycle preload and command: read-before-write
    do_cmd(4'd0, 3'd1, 3'd0, 3'd5, 1'b1, 32'd0, 0, 1'b1, 3'd1, 32'd9, got);
    check("rbw_old", got, 32'd5);
    do_cmd(4'd0, 3'd1, 3'd0, 3'd5, 1'b1, 32'd0, 0, 1'b0, 3'd0, 32'd0, got);
    check("rbw_new", got, 32'd9);

    // Random commands, preloads and stalls
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) preload(3'($urandom_range(0, 7)), $urandom);
      do_cmd(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
             int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
             3'($urandom_range(0, 7)), $urandom, got);
    end

    // Reset during EXEC aborts the command
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_op     = 4'd0;
    cmd_rs1    = 3'd1;
    cmd_rs2    = 3'd1;
    cmd_rd     = 3'd2;
    cmd_imm_en = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("pre_abort_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_alu_a", alu_a, 32'd0);
    @(posedge clk);
    #1;
    check("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) rf[i] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("post_abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    end
    for (int i = 0; i < 8; i++) begin
      do_cmd(4'd0, 3'(i), 3'(i), 3'(i), 1'b0, 32'd0, 0, 1'b0, 3'd0, 32'd0, got);
      check("reg_cleared", got, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
